// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// so one instruction spans 2-5 cycles, with a retire pulse, retired count and sticky illegal halt.
module multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    output logic             PCWr,
    output logic             IRWr,
    output logic             Branch,
    output logic             Jump,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWr,
    output logic             MemWr,
    output logic             Extop,
    output logic [4:0]       ALUctr,
    output logic             retire,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEMRD, MEMWR, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_J, C_JAL, C_JR, C_JALR, C_BR, C_LW, C_ST, C_RALU, C_IALU
    } iclass_t;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND = 5'd2, ALU_OR  = 5'd3,
        ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT = 5'd6, ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA = 5'd10, ALU_LUI = 5'd11
    } aluop_t;

    state_t           r_state;
    logic [5:0]       r_op;
    logic [5:0]       r_func;
    logic             r_postReset;
    logic [CNT_W-1:0] r_icount;

    logic [5:0]       w_op;
    logic [5:0]       w_func;
    iclass_t          w_class;
    aluop_t           w_aluCtr;
    logic             w_aluSrc;
    logic             w_extop;
    logic             w_active;

    // DECODE looks at the live decoder fields; every later state uses the copy latched there.
    assign w_op   = (r_state == DECODE) ? op   : r_op;
    assign w_func = (r_state == DECODE) ? func : r_func;

    always_comb begin
        w_class  = C_ILL;
        w_aluCtr = ALU_ADD;
        w_aluSrc = 1'b0;
        w_extop  = 1'b0;
        case (w_op)
            6'h00: begin
                w_class = C_RALU;
                case (w_func)
                    6'h21:   w_aluCtr = ALU_ADD;
                    6'h23:   w_aluCtr = ALU_SUB;
                    6'h24:   w_aluCtr = ALU_AND;
                    6'h25:   w_aluCtr = ALU_OR;
                    6'h26:   w_aluCtr = ALU_XOR;
                    6'h27:   w_aluCtr = ALU_NOR;
                    6'h2A:   w_aluCtr = ALU_SLT;
                    6'h2B:   w_aluCtr = ALU_SLTU;
                    6'h00:   w_aluCtr = ALU_SLL;
                    6'h02:   w_aluCtr = ALU_SRL;
                    6'h03:   w_aluCtr = ALU_SRA;
                    6'h08:   w_class  = C_JR;
                    6'h09:   w_class  = C_JALR;
                    default: w_class  = C_ILL;
                endcase
            end
            6'h09: begin w_class = C_IALU; w_aluCtr = ALU_ADD;  w_aluSrc = 1'b1; w_extop = 1'b1; end
            6'h0C: begin w_class = C_IALU; w_aluCtr = ALU_AND;  w_aluSrc = 1'b1; end
            6'h0D: begin w_class = C_IALU; w_aluCtr = ALU_OR;   w_aluSrc = 1'b1; end
            6'h0E: begin w_class = C_IALU; w_aluCtr = ALU_XOR;  w_aluSrc = 1'b1; end
            6'h0F: begin w_class = C_IALU; w_aluCtr = ALU_LUI;  w_aluSrc = 1'b1; end
            6'h0A: begin w_class = C_IALU; w_aluCtr = ALU_SLT;  w_aluSrc = 1'b1; w_extop = 1'b1; end
            6'h0B: begin w_class = C_IALU; w_aluCtr = ALU_SLTU; w_aluSrc = 1'b1; w_extop = 1'b1; end
            6'h23: begin w_class = C_LW;   w_aluCtr = ALU_ADD;  w_aluSrc = 1'b1; w_extop = 1'b1; end
            6'h2B,
            6'h28: begin w_class = C_ST;   w_aluCtr = ALU_ADD;  w_aluSrc = 1'b1; w_extop = 1'b1; end
            6'h04,
            6'h05: begin w_class = C_BR;   w_aluCtr = ALU_SUB; end
            6'h02: w_class = C_J;
            6'h03: w_class = C_JAL;
            default: w_class = C_ILL;
        endcase
    end

    // The cycle right after reset is an idle FETCH with all outputs low; the real fetch follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_op        <= '0;
            r_func      <= '0;
            r_postReset <= 1'b1;
            r_icount    <= '0;
        end else begin
            r_postReset <= 1'b0;
            if (retire) begin
                r_icount <= r_icount + CNT_W'(1);
            end
            case (r_state)
                FETCH: begin
                    if (!r_postReset) begin
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_op   <= op;
                    r_func <= func;
                    case (w_class)
                        C_J, C_JAL, C_JR, C_JALR: r_state <= FETCH;
                        C_ILL:   r_state <= ILLEGAL_HALT ? HALT : FETCH;
                        default: r_state <= EXEC;
                    endcase
                end
                EXEC: begin
                    case (w_class)
                        C_BR:    r_state <= FETCH;
                        C_LW:    r_state <= MEMRD;
                        C_ST:    r_state <= MEMWR;
                        default: r_state <= WB;
                    endcase
                end
                MEMRD:   r_state <= WB;
                MEMWR:   r_state <= FETCH;
                WB:      r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Reset gates every output so an aborted instruction never writes PC, registers or memory.
    assign w_active = !reset && !r_postReset;

    always_comb begin
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        Extop    = 1'b0;
        ALUctr   = 5'd0;
        retire   = 1'b0;
        halted   = 1'b0;
        if (w_active) begin
            case (r_state)
                FETCH: IRWr = 1'b1;
                DECODE: begin
                    case (w_class)
                        C_J:    begin Jump = 1'b1; PCWr = 1'b1; retire = 1'b1; end
                        C_JAL:  begin Jump = 1'b1; RegWr = 1'b1; PCWr = 1'b1; retire = 1'b1; end
                        C_JR:   begin PCWr = 1'b1; retire = 1'b1; end
                        C_JALR: begin RegWr = 1'b1; PCWr = 1'b1; retire = 1'b1; end
                        C_ILL: begin
                            if (!ILLEGAL_HALT) begin
                                PCWr   = 1'b1;
                                retire = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                EXEC, MEMRD, MEMWR, WB: begin
                    ALUctr   = w_aluCtr;
                    ALUSrc   = w_aluSrc;
                    Extop    = w_extop;
                    RegDst   = (w_class == C_RALU);
                    MemtoReg = (w_class == C_LW);
                    if (r_state == EXEC && w_class == C_BR) begin
                        Branch = 1'b1;
                        PCWr   = 1'b1;
                        retire = 1'b1;
                    end
                    if (r_state == MEMWR) begin
                        MemWr  = 1'b1;
                        PCWr   = 1'b1;
                        retire = 1'b1;
                    end
                    if (r_state == WB) begin
                        RegWr  = 1'b1;
                        PCWr   = 1'b1;
                        retire = 1'b1;
                    end
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign icount = r_icount;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: a table-driven instruction model predicts
// the per-cycle control word and retired count for a halting build and a NOP/4-bit-counter build.
module tb_multicycle_ctrl;

    localparam int B_PCWR = 16, B_IRWR = 15, B_BRANCH = 14, B_JUMP = 13, B_REGDST = 12;
    localparam int B_ALUSRC = 11, B_MEMTOREG = 10, B_REGWR = 9, B_MEMWR = 8, B_EXTOP = 7;
    localparam int B_RETIRE = 1, B_HALTED = 0;

    localparam logic [5:0] ALL_FUNC [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                             6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
    localparam logic [4:0] R_ALU    [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                             5'd8, 5'd9, 5'd10};
    localparam logic [5:0] ALL_OP   [14] = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B,
                                             6'h23, 6'h2B, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03};
    localparam logic [5:0] I_OP     [7]  = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B};
    localparam logic [4:0] I_ALU    [7]  = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd11, 5'd6, 5'd7};
    localparam logic       I_EXT    [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    typedef struct packed {
        logic       legal;
        logic [2:0] cycles;
        logic       jump;
        logic       link;
        logic       branch;
        logic       store;
        logic       writesReg;
        logic       src;
        logic       ext;
        logic       rdst;
        logic       mtr;
        logic [4:0] alu;
    } info_t;

    logic        clk = 1'b0;
    logic        resetA, resetB;
    logic [5:0]  op, func;

    logic        aPCWr, aIRWr, aBranch, aJump, aRegDst, aALUSrc, aMemtoReg, aRegWr, aMemWr, aExtop;
    logic [4:0]  aALUctr;
    logic        aRetire, aHalted;
    logic [31:0] aIcount;
    logic        bPCWr, bIRWr, bBranch, bJump, bRegDst, bALUSrc, bMemtoReg, bRegWr, bMemWr, bExtop;
    logic [4:0]  bALUctr;
    logic        bRetire, bHalted;
    logic [3:0]  bIcount;
    logic [16:0] wordA, wordB;

    bit          useB;
    logic [31:0] countModel;
    int          vectors;
    int          miscompares;

    multicycle_ctrl dutA (
        .clk(clk), .reset(resetA), .op(op), .func(func),
        .PCWr(aPCWr), .IRWr(aIRWr), .Branch(aBranch), .Jump(aJump), .RegDst(aRegDst),
        .ALUSrc(aALUSrc), .MemtoReg(aMemtoReg), .RegWr(aRegWr), .MemWr(aMemWr), .Extop(aExtop),
        .ALUctr(aALUctr), .retire(aRetire), .halted(aHalted), .icount(aIcount)
    );

    multicycle_ctrl #(.ILLEGAL_HALT(1'b0), .CNT_W(4)) dutB (
        .clk(clk), .reset(resetB), .op(op), .func(func),
        .PCWr(bPCWr), .IRWr(bIRWr), .Branch(bBranch), .Jump(bJump), .RegDst(bRegDst),
        .ALUSrc(bALUSrc), .MemtoReg(bMemtoReg), .RegWr(bRegWr), .MemWr(bMemWr), .Extop(bExtop),
        .ALUctr(bALUctr), .retire(bRetire), .halted(bHalted), .icount(bIcount)
    );

    assign wordA = {aPCWr, aIRWr, aBranch, aJump, aRegDst, aALUSrc, aMemtoReg, aRegWr, aMemWr,
                    aExtop, aALUctr, aRetire, aHalted};
    assign wordB = {bPCWr, bIRWr, bBranch, bJump, bRegDst, bALUSrc, bMemtoReg, bRegWr, bMemWr,
                    bExtop, bALUctr, bRetire, bHalted};

    always #5 clk = ~clk;

    // Instruction semantics as a lookup over the supported-instruction tables.
    function automatic info_t describe(input logic [5:0] o, input logic [5:0] f);
        info_t i;
        i = '0;
        if (o == 6'h00) begin
            for (int n = 0; n < 11; n++) begin
                if (f == ALL_FUNC[n]) begin
                    i.legal = 1'b1; i.cycles = 3'd4; i.alu = R_ALU[n];
                    i.rdst = 1'b1; i.writesReg = 1'b1;
                end
            end
            if (f == 6'h08) begin i.legal = 1'b1; i.cycles = 3'd2; end
            if (f == 6'h09) begin i.legal = 1'b1; i.cycles = 3'd2; i.link = 1'b1; end
        end else begin
            for (int n = 0; n < 7; n++) begin
                if (o == I_OP[n]) begin
                    i.legal = 1'b1; i.cycles = 3'd4; i.alu = I_ALU[n];
                    i.src = 1'b1; i.ext = I_EXT[n]; i.writesReg = 1'b1;
                end
            end
            if (o == 6'h23) begin
                i.legal = 1'b1; i.cycles = 3'd5; i.src = 1'b1; i.ext = 1'b1;
                i.mtr = 1'b1; i.writesReg = 1'b1;
            end
            if (o == 6'h2B || o == 6'h28) begin
                i.legal = 1'b1; i.cycles = 3'd4; i.src = 1'b1; i.ext = 1'b1; i.store = 1'b1;
            end
            if (o == 6'h04 || o == 6'h05) begin
                i.legal = 1'b1; i.cycles = 3'd3; i.alu = 5'd1; i.branch = 1'b1;
            end
            if (o == 6'h02) begin i.legal = 1'b1; i.cycles = 3'd2; i.jump = 1'b1; end
            if (o == 6'h03) begin i.legal = 1'b1; i.cycles = 3'd2; i.jump = 1'b1; i.link = 1'b1; end
        end
        return i;
    endfunction

    // Expected control word for cycle k of an instruction (k=0 is its fetch).
    function automatic logic [16:0] expWord(input info_t i, input int k, input bit nopIllegal);
        logic [16:0] w;
        w = '0;
        if (k == 0) begin
            w[B_IRWR] = 1'b1;
        end else if (!i.legal) begin
            w[B_PCWR]   = nopIllegal;
            w[B_RETIRE] = nopIllegal;
        end else if (i.cycles == 3'd2) begin
            w[B_JUMP]   = i.jump;
            w[B_REGWR]  = i.link;
            w[B_PCWR]   = 1'b1;
            w[B_RETIRE] = 1'b1;
        end else if (k >= 2) begin
            w[6:2]        = i.alu;
            w[B_ALUSRC]   = i.src;
            w[B_EXTOP]    = i.ext;
            w[B_REGDST]   = i.rdst;
            w[B_MEMTOREG] = i.mtr;
            if (k == int'(i.cycles) - 1) begin
                w[B_PCWR]   = 1'b1;
                w[B_RETIRE] = 1'b1;
                w[B_BRANCH] = i.branch;
                w[B_MEMWR]  = i.store;
                w[B_REGWR]  = i.writesReg;
            end
        end
        return w;
    endfunction

    function automatic logic [16:0] curWord();
        return useB ? wordB : wordA;
    endfunction

    function automatic logic [31:0] curCount();
        return useB ? {28'd0, bIcount} : aIcount;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [16:0] expW, input bit withCount);
        checkOutput(tag, {15'd0, curWord()}, {15'd0, expW});
        if (withCount) begin
            checkOutput({tag, " icount"}, curCount(), useB ? (countModel & 32'hF) : countModel);
        end
        if (expW[B_RETIRE]) begin
            countModel = countModel + 32'd1;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setReset(input bit v);
        if (useB) resetB = v;
        else      resetA = v;
    endtask

    task automatic applyReset(input int n);
        countModel = '0;
        for (int i = 0; i < n; i++) begin
            setReset(1'b1);
            op   = 6'($urandom);
            func = 6'($urandom);
            @(negedge clk);
            checkCycle("reset", '0, i > 0);
            nextCycle();
        end
        setReset(1'b0);
        @(negedge clk);
        checkCycle("post-reset", '0, 1'b1);
        nextCycle();
    endtask

    // Runs one instruction; abortAt asserts reset in that cycle, haltCycles observes a halt.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input int abortAt,
                                 input int haltCycles);
        info_t inf;
        int    n;
        inf = describe(o, f);
        n   = inf.legal ? int'(inf.cycles) : 2;
        for (int k = 0; k < n; k++) begin
            op   = (k == 1) ? o : 6'($urandom);
            func = (k == 1) ? f : 6'($urandom);
            if (k == abortAt) begin
                setReset(1'b1);
                @(negedge clk);
                checkCycle($sformatf("abort op%02h", o), '0, 1'b0);
                nextCycle();
                setReset(1'b0);
                countModel = '0;
                @(negedge clk);
                checkCycle("post-abort", '0, 1'b1);
                nextCycle();
                return;
            end
            @(negedge clk);
            checkCycle($sformatf("op%02h/%02h k%0d", o, f, k), expWord(inf, k, useB), 1'b1);
            nextCycle();
        end
        if (!inf.legal && !useB) begin
            for (int h = 0; h < haltCycles; h++) begin
                op   = 6'($urandom);
                func = 6'($urandom);
                @(negedge clk);
                checkCycle($sformatf("halt h%0d", h), 17'd1 << B_HALTED, 1'b1);
                nextCycle();
            end
        end
    endtask

    task automatic pickLegal(output logic [5:0] o, output logic [5:0] f);
        int n;
        n = $urandom_range(0, 26);
        if (n < 13) begin
            o = 6'h00;
            f = ALL_FUNC[n];
        end else begin
            o = ALL_OP[n - 13];
            f = 6'($urandom);
        end
    endtask

    initial begin
        logic [5:0] o, f;
        resetA      = 1'b1;
        resetB      = 1'b1;
        op          = '0;
        func        = '0;
        useB        = 1'b0;
        countModel  = '0;
        vectors     = 0;
        miscompares = 0;
        @(posedge clk);
        #1;

        applyReset(2);
        applyStimulus(6'h00, 6'h21, -1, 0);
        applyStimulus(6'h23, 6'h15, -1, 0);
        applyStimulus(6'h2B, 6'h07, -1, 0);
        applyStimulus(6'h04, 6'h3C, -1, 0);
        applyStimulus(6'h03, 6'h11, -1, 0);
        repeat (40) begin
            pickLegal(o, f);
            applyStimulus(o, f, -1, 0);
        end
        applyStimulus(6'h2B, 6'h00, 3, 0);
        applyStimulus(6'h00, 6'h21, -1, 0);
        applyStimulus(6'h3F, 6'h00, -1, 20);
        applyReset(2);
        applyStimulus(6'h00, 6'h21, -1, 0);

        resetA = 1'b1;
        useB   = 1'b1;
        applyReset(2);
        repeat (16) begin
            pickLegal(o, f);
            applyStimulus(o, f, -1, 0);
        end
        checkOutput("icount wrap", curCount(), 32'd0);
        applyStimulus(6'h3F, 6'h00, -1, 0);
        applyStimulus(6'h00, 6'h3F, -1, 0);
        repeat (30) begin
            applyStimulus(6'($urandom), 6'($urandom), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
